pipe_stage_reg: RTL and testbench

- Parametrised, handshaked successor to the fixed inter-stage pipeline registers such as ID/EX.
- Sits between any two pipeline stages: upstream stage → this block → downstream stage.
- Payload is split into two fields:
  - control field: zeroed whenever the slot is empty or flushed, so an empty slot is a bubble;
  - data field: PC, immediates, operands, register addresses.
- Adds valid/ready back-pressure, an optional skid buffer, synchronous flush, and stall/bubble performance counters.

---
 rtl/pipe_stage_reg.sv | 162 ++++++++++++++++
 tb/tb_pipe_stage_reg.sv | 230 +++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_stage_reg.sv
// Handshaked inter-stage pipeline register with an optional skid buffer.
// Carries a control field (zeroed whenever its slot is empty, so an empty
// slot is a bubble) and an opaque data field. Supports synchronous flush
// and provides saturating stall/bubble performance counters.
module pipe_stage_reg #(
  parameter int CTRL_W  = 16,
  parameter int DATA_W  = 128,
  parameter int SKID_EN = 1,
  parameter int CNT_W   = 16
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              flush,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [CTRL_W-1:0] in_ctrl,
  input  logic [DATA_W-1:0] in_data,
  output logic              out_valid,
  input  logic              out_ready,
  output logic [CTRL_W-1:0] out_ctrl,
  output logic [DATA_W-1:0] out_data,
  output logic [CNT_W-1:0]  stall_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  // Main slot: drives the out_* ports straight from flops.
  logic              main_vld_q, main_vld_d;
  logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
  logic [DATA_W-1:0] main_data_q, main_data_d;

  logic [CNT_W-1:0]  stall_q, stall_d;
  logic [CNT_W-1:0]  bubble_q, bubble_d;

  logic in_xfer, out_xfer;

  assign in_xfer    = in_valid & in_ready;
  assign out_xfer   = main_vld_q & out_ready;

  assign out_valid  = main_vld_q;
  assign out_ctrl   = main_ctrl_q;
  assign out_data   = main_data_q;
  assign stall_cnt  = stall_q;
  assign bubble_cnt = bubble_q;

  generate
    if (SKID_EN != 0) begin : g_skid
      // Skid slot absorbs the one entry accepted while main is stalled,
      // which lets in_ready come from a flop instead of out_ready.
      logic              skid_vld_q, skid_vld_d;
      logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
      logic [DATA_W-1:0] skid_data_q, skid_data_d;

      assign in_ready = ~skid_vld_q;

      // Next state of main and skid; flush wins, then skid drains before new input.
      always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        skid_vld_d  = skid_vld_q;
        skid_ctrl_d = skid_ctrl_q;
        skid_data_d = skid_data_q;
        if (flush) begin
          // Data is left as-is; only valid and ctrl define a bubble.
          main_vld_d  = 1'b0;
          main_ctrl_d = '0;
          skid_vld_d  = 1'b0;
          skid_ctrl_d = '0;
        end else if (!main_vld_q || out_xfer) begin
          if (skid_vld_q) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = skid_ctrl_q;
            main_data_d = skid_data_q;
            // A concurrent accept refills skid; otherwise it becomes a bubble.
            skid_vld_d  = in_xfer;
            skid_ctrl_d = in_xfer ? in_ctrl : '0;
            if (in_xfer) skid_data_d = in_data;
          end else if (in_xfer) begin
            main_vld_d  = 1'b1;
            main_ctrl_d = in_ctrl;
            main_data_d = in_data;
          end else begin
            main_vld_d  = 1'b0;
            main_ctrl_d = '0;
          end
        end else if (in_xfer) begin
          // Main is stalled: park the accepted entry in skid.
          skid_vld_d  = 1'b1;
          skid_ctrl_d = in_ctrl;
          skid_data_d = in_data;
        end
      end

      // Skid slot storage.
      always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
          skid_vld_q  <= 1'b0;
          skid_ctrl_q <= '0;
          skid_data_q <= '0;
        end else begin
          skid_vld_q  <= skid_vld_d;
          skid_ctrl_q <= skid_ctrl_d;
          skid_data_q <= skid_data_d;
        end
      end
    end else begin : g_noskid
      // Single register: accept when empty or when the occupant leaves this cycle.
      assign in_ready = ~main_vld_q | out_ready;

      // Next state of main; flush wins over a concurrent accept.
      always_comb begin
        main_vld_d  = main_vld_q;
        main_ctrl_d = main_ctrl_q;
        main_data_d = main_data_q;
        if (flush) begin
          main_vld_d  = 1'b0;
          main_ctrl_d = '0;
        end else if (in_xfer) begin
          main_vld_d  = 1'b1;
          main_ctrl_d = in_ctrl;
          main_data_d = in_data;
        end else if (out_xfer) begin
          main_vld_d  = 1'b0;
          main_ctrl_d = '0;
        end
      end
    end
  endgenerate

  // Main slot storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      main_vld_q  <= 1'b0;
      main_ctrl_q <= '0;
      main_data_q <= '0;
    end else begin
      main_vld_q  <= main_vld_d;
      main_ctrl_q <= main_ctrl_d;
      main_data_q <= main_data_d;
    end
  end

  // Saturating counters sampled on pre-edge handshake state; flush does not touch them.
  always_comb begin
    stall_d  = stall_q;
    bubble_d = bubble_q;
    if (main_vld_q && !out_ready && !(&stall_q))  stall_d  = stall_q + CNT_W'(1);
    if (!main_vld_q && out_ready && !(&bubble_q)) bubble_d = bubble_q + CNT_W'(1);
  end

  // Counter storage.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      stall_q  <= '0;
      bubble_q <= '0;
    end else begin
      stall_q  <= stall_d;
      bubble_q <= bubble_d;
    end
  end

endmodule

// File: tb/tb_pipe_stage_reg.sv
// Bench for pipe_stage_reg: a skid-buffered instance checked by a scoreboard
// plus counter model, and a no-skid 4-bit-counter instance checked directly.
module tb_pipe_stage_reg;

  logic clk = 1'b0;
  logic rst_n = 1'b1;
  always #5 clk = ~clk;

  int ntests = 0;
  int nfail  = 0;

  // Instance A: SKID_EN=1, 16-bit counters
  logic         a_flush, a_in_valid, a_in_ready, a_out_valid, a_out_ready;
  logic [15:0]  a_in_ctrl, a_out_ctrl, a_stall, a_bubble;
  logic [127:0] a_in_data, a_out_data;

  // Instance B: SKID_EN=0, 4-bit counters
  logic         b_flush, b_in_valid, b_in_ready, b_out_valid, b_out_ready;
  logic [15:0]  b_in_ctrl, b_out_ctrl;
  logic [3:0]   b_stall, b_bubble;
  logic [127:0] b_in_data, b_out_data;

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID_EN(1), .CNT_W(16)) u_a (
    .clk(clk), .reset(rst_n), .flush(a_flush),
    .in_valid(a_in_valid), .in_ready(a_in_ready), .in_ctrl(a_in_ctrl), .in_data(a_in_data),
    .out_valid(a_out_valid), .out_ready(a_out_ready), .out_ctrl(a_out_ctrl), .out_data(a_out_data),
    .stall_cnt(a_stall), .bubble_cnt(a_bubble));

  pipe_stage_reg #(.CTRL_W(16), .DATA_W(128), .SKID_EN(0), .CNT_W(4)) u_b (
    .clk(clk), .reset(rst_n), .flush(b_flush),
    .in_valid(b_in_valid), .in_ready(b_in_ready), .in_ctrl(b_in_ctrl), .in_data(b_in_data),
    .out_valid(b_out_valid), .out_ready(b_out_ready), .out_ctrl(b_out_ctrl), .out_data(b_out_data),
    .stall_cnt(b_stall), .bubble_cnt(b_bubble));

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    ntests++;
    assert (obs === exp) else begin
      nfail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Scoreboard and counter model for instance A, evaluated mid-cycle.
  logic [15:0]  q_ctrl[$];
  logic [127:0] q_data[$];
  logic [15:0]  m_stall = '0;
  logic [15:0]  m_bubble = '0;

  initial begin
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        q_ctrl.delete();
        q_data.delete();
        m_stall  = '0;
        m_bubble = '0;
      end
      chk("a_stall_model", a_stall, m_stall);
      chk("a_bubble_model", a_bubble, m_bubble);
      if (rst_n) begin
        if (!a_out_valid) chk("a_empty_ctrl_zero", a_out_ctrl, 16'h0);
        if (a_out_valid && a_out_ready) begin
          chk("a_sb_has_entry", q_data.size() != 0, 1'b1);
          if (q_data.size() != 0) begin
            chk("a_sb_ctrl", a_out_ctrl, q_ctrl.pop_front());
            chk("a_sb_data", a_out_data, q_data.pop_front());
          end
        end
        if (a_flush) begin
          q_ctrl.delete();
          q_data.delete();
        end else if (a_in_valid && a_in_ready) begin
          q_ctrl.push_back(a_in_ctrl);
          q_data.push_back(a_in_data);
        end
        if (a_out_valid && !a_out_ready && m_stall != 16'hFFFF) m_stall++;
        if (!a_out_valid && a_out_ready && m_bubble != 16'hFFFF) m_bubble++;
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  initial begin
    a_flush = 0; a_in_valid = 0; a_out_ready = 0; a_in_ctrl = '0; a_in_data = '0;
    b_flush = 0; b_in_valid = 0; b_out_ready = 0; b_in_ctrl = '0; b_in_data = '0;
    rst_n = 1'b0;
    tick();

    // Reset state
    chk("rst_a_out_valid", a_out_valid, 1'b0);
    chk("rst_a_out_ctrl", a_out_ctrl, 16'h0);
    chk("rst_a_out_data", a_out_data, 128'h0);
    chk("rst_a_in_ready", a_in_ready, 1'b1);
    chk("rst_a_stall", a_stall, 16'h0);
    chk("rst_a_bubble", a_bubble, 16'h0);
    chk("rst_b_in_ready", b_in_ready, 1'b1);
    chk("rst_b_out_valid", b_out_valid, 1'b0);

    // Stream 0x1..0x5 with out_ready=1
    a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 16'hA5A5; a_in_data = 128'h1;
    @(posedge clk); #1 rst_n = 1'b1;
    for (int i = 1; i <= 5; i++) begin
      a_in_data = 128'(i);
      tick();
      chk("stream_valid", a_out_valid, 1'b1);
      chk("stream_data", a_out_data, 128'(i));
      chk("stream_ctrl", a_out_ctrl, 16'hA5A5);
    end
    chk("stream_bubble_cnt", a_bubble, 16'h1);
    a_in_valid = 0;
    tick();
    chk("stream_drain_valid", a_out_valid, 1'b0);
    chk("stream_drain_ctrl", a_out_ctrl, 16'h0);

    // Back-pressure through the skid slot
    a_in_valid = 1; a_in_data = 128'h10;
    tick();
    chk("bp_first", a_out_data, 128'h10);
    a_out_ready = 0; a_in_data = 128'h11;
    tick();
    chk("bp_in_ready_low", a_in_ready, 1'b0);
    a_in_data = 128'h12;
    tick();
    tick();
    chk("bp_stall_cnt", a_stall, 16'h3);
    chk("bp_hold_data", a_out_data, 128'h10);
    chk("bp_still_blocked", a_in_ready, 1'b0);
    a_out_ready = 1;
    tick();
    chk("bp_skid_to_main", a_out_data, 128'h11);
    chk("bp_in_ready_back", a_in_ready, 1'b1);
    tick();
    chk("bp_third", a_out_data, 128'h12);
    a_in_valid = 0;
    tick();
    chk("bp_drained", a_out_valid, 1'b0);

    // Flush with main and skid full while 0x20 is offered
    a_out_ready = 0; a_in_valid = 1; a_in_ctrl = 16'h0F0F; a_in_data = 128'h30;
    tick();
    a_in_data = 128'h31;
    tick();
    chk("fl_full_in_ready", a_in_ready, 1'b0);
    a_flush = 1; a_in_data = 128'h20;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl_out_valid", a_out_valid, 1'b0);
    chk("fl_out_ctrl", a_out_ctrl, 16'h0);
    chk("fl_in_ready", a_in_ready, 1'b1);
    chk("fl_stall_kept", a_stall, 16'h5);

    // Flush while an out-transfer completes and a new entry is offered
    a_out_ready = 1; a_in_valid = 1; a_in_ctrl = 16'h5A5A; a_in_data = 128'h40;
    tick();
    chk("fl2_loaded", a_out_data, 128'h40);
    a_flush = 1; a_in_data = 128'h21;
    tick();
    a_flush = 0; a_in_valid = 0;
    chk("fl2_out_valid", a_out_valid, 1'b0);
    chk("fl2_out_ctrl", a_out_ctrl, 16'h0);
    tick();
    chk("fl2_no_ghost", a_out_valid, 1'b0);

    // Asynchronous reset mid-stream
    a_in_valid = 1; a_in_ctrl = 16'hC3C3; a_in_data = 128'h50;
    tick();
    a_in_data = 128'h51;
    tick();
    chk("ar_pre_valid", a_out_valid, 1'b1);
    a_in_data = 128'h52;
    #2 rst_n = 1'b0;
    #1;
    chk("ar_out_valid", a_out_valid, 1'b0);
    chk("ar_out_ctrl", a_out_ctrl, 16'h0);
    chk("ar_out_data", a_out_data, 128'h0);
    chk("ar_stall", a_stall, 16'h0);
    chk("ar_bubble", a_bubble, 16'h0);
    chk("ar_in_ready", a_in_ready, 1'b1);
    tick();
    chk("ar_held", a_out_valid, 1'b0);
    a_in_data = 128'h60;
    rst_n = 1'b1;
    tick();
    chk("ar_first_valid", a_out_valid, 1'b1);
    chk("ar_first_data", a_out_data, 128'h60);
    a_in_valid = 0;
    tick();
    chk("ar_drained", a_out_valid, 1'b0);

    // SKID_EN=0: combinational in_ready and saturating 4-bit stall counter
    b_in_valid = 1; b_in_ctrl = 16'h1234; b_in_data = 128'h70;
    tick();
    b_in_data = 128'h71;
    chk("ns_in_ready_blocked", b_in_ready, 1'b0);
    repeat (20) tick();
    chk("ns_stall_sat", b_stall, 4'hF);
    chk("ns_hold_data", b_out_data, 128'h70);
    b_out_ready = 1;
    #1;
    chk("ns_in_ready_comb", b_in_ready, 1'b1);
    tick();
    chk("ns_replace1_valid", b_out_valid, 1'b1);
    chk("ns_replace1_data", b_out_data, 128'h71);
    b_in_data = 128'h72;
    tick();
    chk("ns_replace2_data", b_out_data, 128'h72);
    chk("ns_replace2_ctrl", b_out_ctrl, 16'h1234);
    b_in_valid = 0;
    tick();
    chk("ns_drain_valid", b_out_valid, 1'b0);
    chk("ns_drain_ctrl", b_out_ctrl, 16'h0);
    chk("ns_stall_stays_sat", b_stall, 4'hF);

    tick();
    chk("a_sb_drained", q_data.size(), 0);
    $display("[TB] %0d tests run, %0d failed", ntests, nfail);
    $finish;
  end

endmodule
